// File: rtl/console_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// console_arb_pkg
// Shared definitions for the console arbiter: FSM state encoding, the console
// data width and the newline byte that ends a locked line.
// ----------------------------------------------------------------------------
package console_arb_pkg;

    localparam int CON_DW = 32;

    // Byte that terminates a line and releases a line lock.
    localparam logic [7:0] NEWLINE = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // no owner, arbitrate among all requesters
        ST_ISSUE    = 2'd1,  // strobe presented to the console, waiting for stall=0
        ST_WAIT_ACK = 2'd2,  // strobe taken, waiting for the console ack
        ST_LOCK     = 2'd3   // owner holds the console until newline or timeout
    } arb_state_t;

endpackage

// File: rtl/console_arbiter_if.sv
// ----------------------------------------------------------------------------
// console_arbiter_if
// Wishbone-style console byte sink bus (pipelined stb/stall/ack).
//   con_stb   : master -> slave, transfer strobe
//   con_data  : master -> slave, transfer data, byte in [7:0]
//   con_ack   : slave -> master, transfer completed
//   con_stall : slave -> master, strobe not taken this cycle
// ----------------------------------------------------------------------------
interface console_arbiter_if;
    import console_arb_pkg::*;

    logic              con_stb;
    logic [CON_DW-1:0] con_data;
    logic              con_ack;
    logic              con_stall;

    modport master (
        output con_stb,
        output con_data,
        input  con_ack,
        input  con_stall
    );

    modport slave (
        input  con_stb,
        input  con_data,
        output con_ack,
        output con_stall
    );

endinterface

// File: rtl/console_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Searches req_i starting at last_i+1 and
// wrapping, and returns the first set bit as a one-hot grant.
//   req_i   : request vector
//   last_i  : index of the previous winner (lowest priority this round)
//   grant_o : one-hot winner, all zero when nothing is requested
//   valid_o : at least one request present
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             valid_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned infers a latch.
        grant_o = '0;
        valid_o = 1'b0;
        // off walks the priority order; k only ever indexes with a loop
        // constant, so the search stays a fixed priority mux after unrolling.
        for (int off = 1; off <= N_REQ; off++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!valid_o && req_i[k] && (k == (int'(last_i) + off) % N_REQ)) begin
                    grant_o[k] = 1'b1;
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/console_arbiter.sv
// ----------------------------------------------------------------------------
// console_arbiter
// Shares one console byte sink between N_REQ requesters, round-robin, one
// transfer outstanding. With LINE_LOCK the owner keeps the console until it
// writes a newline or stays idle for LOCK_TIMEOUT cycles.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req_stb      : per-requester strobe
//   i_req_data     : per-requester data, requester k at [32k+31:32k]
//   o_req_ack      : one-cycle ack to the owner of the completed transfer
//   o_req_stall    : combinational, 0 only for the requester accepted now
//   con            : console bus (master side)
//   o_grant        : one-hot current owner, 0 when idle
//   o_locked       : owner holds a line lock
// ----------------------------------------------------------------------------
module console_arbiter
    import console_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter bit LINE_LOCK    = 1'b1,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_REQ-1:0]        i_req_stb,
    input  logic [CON_DW*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ack,
    output logic [N_REQ-1:0]        o_req_stall,
    console_arbiter_if.master       con,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_locked
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic              con_stb_q, con_stb_d;
    logic [CON_DW-1:0] con_data_q, con_data_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              locked_q, locked_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick_req, pick_grant;
    logic              pick_valid, accept;
    logic [CON_DW-1:0] sel_data;
    logic [IDX_W-1:0]  owner_idx;

    // In LOCK only the owner may compete, so the same picker serves both
    // the free-for-all and the locked case.
    assign pick_req = (state_q == ST_LOCK) ? (i_req_stb & grant_q) : i_req_stb;

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req_i   (pick_req),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    assign accept      = pick_valid && ((state_q == ST_IDLE) || (state_q == ST_LOCK));
    assign o_req_stall = accept ? ~pick_grant : '1;

    always_comb begin
        sel_data  = '0;
        owner_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) sel_data  = i_req_data[CON_DW*k +: CON_DW];
            if (grant_q[k])    owner_idx = IDX_W'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        con_stb_d  = con_stb_q;
        con_data_d = con_data_q;
        req_ack_d  = '0;
        grant_d    = grant_q;
        locked_d   = locked_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE, ST_LOCK: begin
                if (accept) begin
                    // An owner strobe beats a timeout in the same cycle.
                    con_data_d = sel_data;
                    con_stb_d  = 1'b1;
                    grant_d    = pick_grant;
                    cnt_d      = '0;
                    state_d    = ST_ISSUE;
                end else if (state_q == ST_LOCK) begin
                    if (cnt_q >= CNT_LAST) begin
                        last_d   = owner_idx;
                        grant_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!con.con_stall) begin
                    con_stb_d = 1'b0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (con.con_ack) begin
                    req_ack_d = grant_q;
                    if (LINE_LOCK && (con_data_q[7:0] != NEWLINE)) begin
                        cnt_d    = '0;
                        locked_d = 1'b1;
                        state_d  = ST_LOCK;
                    end else begin
                        last_d   = owner_idx;
                        grant_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            con_stb_q  <= 1'b0;
            con_data_q <= '0;
            req_ack_q  <= '0;
            grant_q    <= '0;
            locked_q   <= 1'b0;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            con_stb_q  <= con_stb_d;
            con_data_q <= con_data_d;
            req_ack_q  <= req_ack_d;
            grant_q    <= grant_d;
            locked_q   <= locked_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign con.con_stb  = con_stb_q;
    assign con.con_data = con_data_q;
    assign o_req_ack    = req_ack_q;
    assign o_grant      = grant_q;
    assign o_locked     = locked_q;

endmodule

// File: tb/tb_console_arbiter.sv
// ----------------------------------------------------------------------------
// tb_console_arbiter
// dut_a: LINE_LOCK=0, driven cycle by cycle from a vector table.
// dut_b: LINE_LOCK=1, LOCK_TIMEOUT=4, driven by hand sequences against a
// console model that acks the cycle after it takes a strobe.
// Inputs change #1 after posedge; outputs are sampled on the negedge.
// ----------------------------------------------------------------------------
module tb_console_arbiter;
    import console_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  a_stb, a_ack, a_stall, a_grant;
    logic [63:0] a_data;
    logic        a_locked;
    logic [1:0]  b_stb, b_ack, b_stall, b_grant;
    logic [63:0] b_data;
    logic        b_locked;

    console_arbiter_if a_if ();
    console_arbiter_if b_if ();

    console_arbiter #(.N_REQ(2), .LINE_LOCK(1'b0), .LOCK_TIMEOUT(4)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_req_stb(a_stb), .i_req_data(a_data),
        .o_req_ack(a_ack), .o_req_stall(a_stall), .con(a_if.master),
        .o_grant(a_grant), .o_locked(a_locked)
    );

    console_arbiter #(.N_REQ(2), .LINE_LOCK(1'b1), .LOCK_TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_req_stb(b_stb), .i_req_data(b_data),
        .o_req_ack(b_ack), .o_req_stall(b_stall), .con(b_if.master),
        .o_grant(b_grant), .o_locked(b_locked)
    );

    // Console model for dut_b: acks one cycle after a strobe is taken.
    always @(posedge clk) begin
        if (rst) b_if.con_ack <= 1'b0;
        else     b_if.con_ack <= b_if.con_stb && !b_if.con_stall;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst   = 1'b1;
        b_stb = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] stb;
        logic [7:0] d0, d1;
        bit         ack, stall;
        logic [1:0] e_grant, e_stall;
        bit         e_stb;
        logic [7:0] e_data;
        logic [1:0] e_ack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [1:0] s, logic [7:0] d0, logic [7:0] d1,
                                bit ak, bit st, logic [1:0] eg, logic [1:0] es,
                                bit eb, logic [7:0] ed, logic [1:0] ea);
        vec_t v;
        v.rst = r; v.stb = s; v.d0 = d0; v.d1 = d1; v.ack = ak; v.stall = st;
        v.e_grant = eg; v.e_stall = es; v.e_stb = eb; v.e_data = ed; v.e_ack = ea;
        return v;
    endfunction

    logic [7:0] line_msg [3];
    logic [7:0] cap_b [$];
    logic       cap_l [$];
    int         cap_t [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            rst stb  d0     d1     ak st | grant stall stb data  ack
        // single requester
        vecs.push_back(mk(0, 2'b01, 8'h41, 8'h00, 0, 0, 2'b00, 2'b10, 0, 8'h00, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h41, 8'h00, 0, 0, 2'b01, 2'b11, 1, 8'h41, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 0, 2'b01, 2'b11, 0, 8'h41, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 2'b11, 0, 8'h41, 2'b01));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 2'b11, 0, 8'h41, 2'b00));
        // reset so requester 0 leads the contention run
        vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 2'b11, 0, 8'h41, 2'b00));
        // contention A,B,A,B
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b00, 2'b10, 0, 8'h00, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b01, 2'b11, 1, 8'h41, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 1, 0, 2'b01, 2'b11, 0, 8'h41, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b00, 2'b01, 0, 8'h41, 2'b01));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b10, 2'b11, 1, 8'h42, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 1, 0, 2'b10, 2'b11, 0, 8'h42, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b00, 2'b10, 0, 8'h42, 2'b10));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b01, 2'b11, 1, 8'h41, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 1, 0, 2'b01, 2'b11, 0, 8'h41, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h42, 0, 0, 2'b00, 2'b01, 0, 8'h41, 2'b01));
        vecs.push_back(mk(0, 2'b00, 8'h41, 8'h42, 0, 0, 2'b10, 2'b11, 1, 8'h42, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h41, 8'h42, 1, 0, 2'b10, 2'b11, 0, 8'h42, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h41, 8'h42, 0, 0, 2'b00, 2'b11, 0, 8'h42, 2'b10));
        // console stall for 3 cycles
        vecs.push_back(mk(0, 2'b01, 8'h5A, 8'h00, 0, 0, 2'b00, 2'b10, 0, 8'h42, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 0, 1, 2'b01, 2'b11, 1, 8'h5A, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 0, 1, 2'b01, 2'b11, 1, 8'h5A, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 0, 1, 2'b01, 2'b11, 1, 8'h5A, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 0, 0, 2'b01, 2'b11, 1, 8'h5A, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 1, 0, 2'b01, 2'b11, 0, 8'h5A, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 0, 0, 2'b00, 2'b11, 0, 8'h5A, 2'b01));
        vecs.push_back(mk(0, 2'b00, 8'h5A, 8'h00, 0, 0, 2'b00, 2'b11, 0, 8'h5A, 2'b00));
        // reset in WAIT_ACK, stray ack afterwards, req0 wins next
        vecs.push_back(mk(0, 2'b10, 8'h00, 8'h31, 0, 0, 2'b00, 2'b01, 0, 8'h5A, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h31, 0, 0, 2'b10, 2'b11, 1, 8'h31, 2'b00));
        vecs.push_back(mk(1, 2'b00, 8'h00, 8'h31, 0, 0, 2'b10, 2'b11, 0, 8'h31, 2'b00));
        vecs.push_back(mk(0, 2'b11, 8'h30, 8'h31, 1, 0, 2'b00, 2'b10, 0, 8'h00, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h30, 8'h31, 0, 0, 2'b01, 2'b11, 1, 8'h30, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h30, 8'h31, 1, 0, 2'b01, 2'b11, 0, 8'h30, 2'b00));
        vecs.push_back(mk(0, 2'b00, 8'h30, 8'h31, 0, 0, 2'b00, 2'b11, 0, 8'h30, 2'b01));

        line_msg[0] = 8'h68; line_msg[1] = 8'h69; line_msg[2] = NEWLINE;

        rst = 1'b1;
        a_stb = '0; a_data = '0; a_if.con_ack = 1'b0; a_if.con_stall = 1'b0;
        b_stb = '0; b_data = '0; b_if.con_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst a_grant", 32'(a_grant), 32'h0);
        check("rst a_ack", 32'(a_ack), 32'h0);
        check("rst a_con_stb", 32'(a_if.con_stb), 32'h0);
        check("rst a_con_data", a_if.con_data, 32'h0);
        check("rst b_locked", 32'(b_locked), 32'h0);
        check("rst b_stall", 32'(b_stall), 32'h3);

        // ---------------- vector table on dut_a ----------------
        foreach (vecs[i]) begin
            step();
            rst           = vecs[i].rst;
            a_stb         = vecs[i].stb;
            a_data        = {24'h0, vecs[i].d1, 24'h0, vecs[i].d0};
            a_if.con_ack   = vecs[i].ack;
            a_if.con_stall = vecs[i].stall;
            @(negedge clk);
            check($sformatf("v%0d grant", i), 32'(a_grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d stall", i), 32'(a_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d con_stb", i), 32'(a_if.con_stb), 32'(vecs[i].e_stb));
            check($sformatf("v%0d con_data", i), a_if.con_data, {24'h0, vecs[i].e_data});
            check($sformatf("v%0d req_ack", i), 32'(a_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d locked", i), 32'(a_locked), 32'h0);
        end
        a_stb = '0; a_if.con_ack = 1'b0; a_if.con_stall = 1'b0;

        // ---------------- line lock: req0 "hi\n", req1 'x' ----------------
        do_reset();
        begin
            int  i0 = 0;
            bit  x_done = 1'b0;
            int  ack0 = 0;
            int  ack1 = 0;
            for (int cyc = 0; cyc < 80 && !(x_done && ack1 >= 1); cyc++) begin
                step();
                b_stb[0] = (i0 < 3);
                if (i0 < 3) b_data[7:0] = line_msg[i0];
                b_stb[1] = !x_done;
                b_data[39:32] = 8'h78;
                @(negedge clk);
                if (b_stb[0] && !b_stall[0]) i0++;
                if (b_stb[1] && !b_stall[1]) x_done = 1'b1;
                if (b_if.con_stb && !b_if.con_stall) begin
                    cap_b.push_back(b_if.con_data[7:0]);
                    cap_l.push_back(b_locked);
                    cap_t.push_back(cyc);
                end
                if (b_ack[0]) ack0++;
                if (b_ack[1]) ack1++;
            end
            b_stb = '0;
            check("ll ack0 count", ack0, 3);
            check("ll ack1 count", ack1, 1);
            check("ll byte count", cap_b.size(), 4);
            while (cap_b.size() < 4) begin
                cap_b.push_back(8'hFF); cap_l.push_back(1'bx); cap_t.push_back(-100);
            end
            check("ll byte0", 32'(cap_b[0]), 32'h68);
            check("ll byte1", 32'(cap_b[1]), 32'h69);
            check("ll byte2", 32'(cap_b[2]), 32'h0A);
            check("ll byte3", 32'(cap_b[3]), 32'h78);
            check("ll locked0", 32'(cap_l[0]), 32'h0);
            check("ll locked1", 32'(cap_l[1]), 32'h1);
            check("ll locked2", 32'(cap_l[2]), 32'h1);
            check("ll locked3", 32'(cap_l[3]), 32'h0);
            check("ll newline release gap", cap_t[3] - cap_t[2], 3);
        end

        // ---------------- lock timeout, req1 pending ----------------
        do_reset();
        step(); b_stb = 2'b11; b_data = {24'h0, 8'h62, 24'h0, 8'h61};
        @(negedge clk); check("to s0 stall", 32'(b_stall), 32'h2);
        step(); b_stb = 2'b10;
        @(negedge clk); check("to s1 con_stb", 32'(b_if.con_stb), 32'h1);
        check("to s1 grant", 32'(b_grant), 32'h1);
        step();
        step();
        @(negedge clk); check("to s3 req_ack", 32'(b_ack), 32'h1);
        check("to s3 locked", 32'(b_locked), 32'h1);
        check("to s3 stall", 32'(b_stall), 32'h3);
        step(); step(); step();
        @(negedge clk); check("to s6 grant held", 32'(b_grant), 32'h1);
        check("to s6 locked", 32'(b_locked), 32'h1);
        step();
        @(negedge clk); check("to s7 grant", 32'(b_grant), 32'h0);
        check("to s7 locked", 32'(b_locked), 32'h0);
        check("to s7 stall", 32'(b_stall), 32'h1);
        step(); b_stb = 2'b00;
        @(negedge clk); check("to s8 grant", 32'(b_grant), 32'h2);
        check("to s8 data", b_if.con_data, 32'h62);

        // ---------------- owner strobe in the timeout cycle ----------------
        do_reset();
        step(); b_stb = 2'b01; b_data = {24'h0, 8'h00, 24'h0, 8'h63};
        @(negedge clk); check("tw s0 stall", 32'(b_stall), 32'h2);
        step(); b_stb = 2'b00;
        repeat (5) step();
        b_stb = 2'b01; b_data[7:0] = 8'h64;
        @(negedge clk); check("tw s6 stall", 32'(b_stall), 32'h2);
        step(); b_stb = 2'b00;
        @(negedge clk); check("tw s7 con_stb", 32'(b_if.con_stb), 32'h1);
        check("tw s7 data", b_if.con_data, 32'h64);
        check("tw s7 grant", 32'(b_grant), 32'h1);
        check("tw s7 locked", 32'(b_locked), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
